link_sync_ctrl: RTL and testbench

Link synchronisation controller placed directly after dec_8b_10b on the receive path. It watches the decoder's per-word outputs, acquires lock on K28.5 commas and drives the decoder's running-disparity force controls. It declares link up or down with error hysteresis, gates decoded data to downstream logic and keeps error and loss-of-sync statistics.

---
 rtl/link_sync_ctrl.sv | 131 +++++++++++++
 tb/tb_link_sync_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/link_sync_ctrl.sv
// link_sync_ctrl: comma lock, error hysteresis, data gating and link statistics after dec_8b_10b
//   clk, reset_n (async active-low), enable, err_clr
//   dec_valid, dec_dataout, dec_kout, dec_kerr, dec_rderr : decoder word outputs
//   dec_ena, dec_rdforce, dec_rdin                        : decoder controls
//   link_up, sync_state                                   : link status (0 LOSS, 1 ACQ, 2 SYNC, 3 RECOVER)
//   data_out, k_out, data_valid                           : gated decoded word
//   err_count, lol_count                                  : saturating statistics
module link_sync_ctrl #(
    parameter int COMMA_LOCK_CNT   = 3,
    parameter int ERR_LOSS_CNT     = 4,
    parameter int GOOD_RECOVER_CNT = 4,
    parameter int ERRCNT_W         = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                err_clr,
    input  logic                dec_valid,
    input  logic [7:0]          dec_dataout,
    input  logic                dec_kout,
    input  logic                dec_kerr,
    input  logic                dec_rderr,
    output logic                dec_ena,
    output logic                dec_rdforce,
    output logic                dec_rdin,
    output logic                link_up,
    output logic [1:0]          sync_state,
    output logic [7:0]          data_out,
    output logic                k_out,
    output logic                data_valid,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [7:0]          lol_count
);
    typedef enum logic [1:0] {LOSS = 2'd0, ACQ = 2'd1, SYNC = 2'd2, RECOVER = 2'd3} state_t;
    localparam logic [3:0] LOCK_N = 4'(COMMA_LOCK_CNT);
    localparam logic [3:0] LOSS_N = 4'(ERR_LOSS_CNT);
    localparam logic [3:0] GOOD_N = 4'(GOOD_RECOVER_CNT);
    state_t state;
    logic [3:0] comma_cnt, bad_cnt, good_cnt;
    logic bad, comma, up, word, err_inc, lol_inc;
    logic [ERRCNT_W-1:0] err_base;
    logic [7:0] lol_base;
    assign dec_rdin   = 1'b0;
    assign sync_state = state;
    assign bad        = dec_kerr | dec_rderr;
    assign comma      = dec_kout && dec_dataout == 8'hBC && !bad;
    assign up         = state == SYNC || state == RECOVER;
    assign word       = enable && dec_valid;
    assign err_inc    = word && bad && up;
    assign lol_inc    = word && bad && state == RECOVER && bad_cnt + 4'd1 == LOSS_N;
    // clear first, then count: a coincident event leaves the counter at 1
    assign err_base   = err_clr ? '0 : err_count;
    assign lol_base   = err_clr ? '0 : lol_count;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= LOSS;
            comma_cnt   <= '0;
            bad_cnt     <= '0;
            good_cnt    <= '0;
            dec_ena     <= 1'b0;
            dec_rdforce <= 1'b1;
            link_up     <= 1'b0;
            data_out    <= '0;
            k_out       <= 1'b0;
            data_valid  <= 1'b0;
            err_count   <= '0;
            lol_count   <= '0;
        end else begin
            dec_ena    <= enable;
            data_valid <= word && !bad && up;
            if (word && !bad && up) begin
                data_out <= dec_dataout;
                k_out    <= dec_kout;
            end
            err_count <= (err_inc && !(&err_base)) ? err_base + 1'b1 : err_base;
            lol_count <= (lol_inc && !(&lol_base)) ? lol_base + 1'b1 : lol_base;
            if (!enable) begin
                state       <= LOSS;
                comma_cnt   <= '0;
                bad_cnt     <= '0;
                good_cnt    <= '0;
                link_up     <= 1'b0;
                dec_rdforce <= 1'b1;
            end else if (dec_valid) begin
                case (state)
                    LOSS: if (comma) begin
                        comma_cnt   <= 4'd1;
                        state       <= (LOCK_N == 4'd1) ? SYNC : ACQ;
                        link_up     <= LOCK_N == 4'd1;
                        dec_rdforce <= 1'b0;
                    end
                    ACQ: if (bad) begin
                        state       <= LOSS;
                        comma_cnt   <= '0;
                        dec_rdforce <= 1'b1;
                    end else if (comma) begin
                        comma_cnt <= comma_cnt + 4'd1;
                        if (comma_cnt + 4'd1 == LOCK_N) begin
                            state   <= SYNC;
                            link_up <= 1'b1;
                        end
                    end
                    SYNC: if (bad) begin
                        state    <= RECOVER;
                        bad_cnt  <= 4'd1;
                        good_cnt <= '0;
                    end
                    RECOVER: if (bad) begin
                        good_cnt <= '0;
                        if (bad_cnt + 4'd1 == LOSS_N) begin
                            state       <= LOSS;
                            bad_cnt     <= '0;
                            comma_cnt   <= '0;
                            link_up     <= 1'b0;
                            dec_rdforce <= 1'b1;
                        end else begin
                            bad_cnt <= bad_cnt + 4'd1;
                        end
                    end else if (good_cnt + 4'd1 == GOOD_N) begin
                        // a run of good words retires one outstanding bad word
                        good_cnt <= '0;
                        bad_cnt  <= bad_cnt - 4'd1;
                        if (bad_cnt == 4'd1) state <= SYNC;
                    end else begin
                        good_cnt <= good_cnt + 4'd1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_link_sync_ctrl.sv
// tb_link_sync_ctrl: directed stimulus against a cycle model of link_sync_ctrl plus literal spot checks
module tb_link_sync_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic err_clr = 1'b0;
    logic dec_valid = 1'b0;
    logic [7:0] dec_dataout = 8'h00;
    logic dec_kout = 1'b0;
    logic dec_kerr = 1'b0;
    logic dec_rderr = 1'b0;
    logic dec_ena, dec_rdforce, dec_rdin, link_up, data_valid, k_out;
    logic [1:0] sync_state;
    logic [7:0] data_out, lol_count;
    logic [15:0] err_count;
    logic n_ena, n_rdforce, n_rdin, n_link_up, n_data_valid, n_k_out;
    logic [1:0] n_sync_state;
    logic [7:0] n_data_out, n_lol_count;
    logic [1:0] n_err_count;
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    link_sync_ctrl dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .err_clr(err_clr),
        .dec_valid(dec_valid), .dec_dataout(dec_dataout), .dec_kout(dec_kout),
        .dec_kerr(dec_kerr), .dec_rderr(dec_rderr),
        .dec_ena(dec_ena), .dec_rdforce(dec_rdforce), .dec_rdin(dec_rdin),
        .link_up(link_up), .sync_state(sync_state), .data_out(data_out),
        .k_out(k_out), .data_valid(data_valid), .err_count(err_count), .lol_count(lol_count)
    );

    link_sync_ctrl #(.ERRCNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .err_clr(err_clr),
        .dec_valid(dec_valid), .dec_dataout(dec_dataout), .dec_kout(dec_kout),
        .dec_kerr(dec_kerr), .dec_rderr(dec_rderr),
        .dec_ena(n_ena), .dec_rdforce(n_rdforce), .dec_rdin(n_rdin),
        .link_up(n_link_up), .sync_state(n_sync_state), .data_out(n_data_out),
        .k_out(n_k_out), .data_valid(n_data_valid), .err_count(n_err_count), .lol_count(n_lol_count)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // model state: m_* is what the outputs must show now, x_* is what they must show after the next edge
    int m_st, m_cc, m_bad, m_good, m_err, m_err2, m_lol, m_do, m_ko, m_dv, m_ena;
    int x_st, x_cc, x_bad, x_good, x_err, x_err2, x_lol, x_do, x_ko, x_dv, x_ena;
    logic is_bad, is_comma, linked;

    always_comb begin
        x_st = m_st; x_cc = m_cc; x_bad = m_bad; x_good = m_good;
        x_err = m_err; x_err2 = m_err2; x_lol = m_lol;
        x_do = m_do; x_ko = m_ko; x_dv = 0; x_ena = int'(enable);
        is_bad = dec_kerr || dec_rderr;
        is_comma = dec_kout && dec_dataout == 8'hBC && !is_bad;
        linked = m_st >= 2;
        if (err_clr) begin
            x_err = 0; x_err2 = 0; x_lol = 0;
        end
        if (!enable) begin
            x_st = 0; x_cc = 0; x_bad = 0; x_good = 0;
        end else if (dec_valid) begin
            if (linked && is_bad) begin
                x_err = (x_err >= 65535) ? 65535 : x_err + 1;
                x_err2 = (x_err2 >= 3) ? 3 : x_err2 + 1;
            end
            if (linked && !is_bad) begin
                x_dv = 1; x_do = int'(dec_dataout); x_ko = int'(dec_kout);
            end
            if (m_st == 0) begin
                if (is_comma) begin
                    x_cc = 1;
                    x_st = (x_cc >= 3) ? 2 : 1;
                end
            end else if (m_st == 1) begin
                if (is_bad) begin
                    x_st = 0; x_cc = 0;
                end else if (is_comma) begin
                    x_cc = m_cc + 1;
                    if (x_cc >= 3) x_st = 2;
                end
            end else if (m_st == 2) begin
                if (is_bad) begin
                    x_st = 3; x_bad = 1; x_good = 0;
                end
            end else if (is_bad) begin
                x_bad = m_bad + 1; x_good = 0;
                if (x_bad >= 4) begin
                    x_st = 0; x_bad = 0; x_cc = 0;
                    x_lol = (x_lol >= 255) ? 255 : x_lol + 1;
                end
            end else begin
                x_good = m_good + 1;
                if (x_good == 4) begin
                    x_good = 0; x_bad = m_bad - 1;
                    if (x_bad == 0) x_st = 2;
                end
            end
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_st <= 0; m_cc <= 0; m_bad <= 0; m_good <= 0; m_err <= 0; m_err2 <= 0;
            m_lol <= 0; m_do <= 0; m_ko <= 0; m_dv <= 0; m_ena <= 0;
        end else begin
            m_st <= x_st; m_cc <= x_cc; m_bad <= x_bad; m_good <= x_good; m_err <= x_err;
            m_err2 <= x_err2; m_lol <= x_lol; m_do <= x_do; m_ko <= x_ko; m_dv <= x_dv; m_ena <= x_ena;
        end
    end

    always @(negedge clk) begin
        chk("sync_state", int'(sync_state), m_st);
        chk("link_up", int'(link_up), int'(m_st >= 2));
        chk("dec_rdforce", int'(dec_rdforce), int'(m_st == 0));
        chk("dec_rdin", int'(dec_rdin), 0);
        chk("dec_ena", int'(dec_ena), m_ena);
        chk("data_valid", int'(data_valid), m_dv);
        chk("data_out", int'(data_out), m_do);
        chk("k_out", int'(k_out), m_ko);
        chk("err_count", int'(err_count), m_err);
        chk("lol_count", int'(lol_count), m_lol);
        chk("err_count_w2", int'(n_err_count), m_err2);
        chk("sync_state_w2", int'(n_sync_state), m_st);
    end

    task automatic word(input logic [7:0] d, input logic k, input logic ke, input logic re, input logic ec);
        dec_valid = 1'b1; dec_dataout = d; dec_kout = k; dec_kerr = ke; dec_rderr = re; err_clr = ec;
        @(posedge clk); #2;
        dec_valid = 1'b0; dec_kerr = 1'b0; dec_rderr = 1'b0; err_clr = 1'b0;
    endtask

    task automatic comma();
        word(8'hBC, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic good(input logic [7:0] d);
        word(d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic bad();
        word(8'hE7, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle();
        @(posedge clk); #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_state", int'(sync_state), 0);
        chk("rst_rdforce", int'(dec_rdforce), 1);
        chk("rst_link_up", int'(link_up), 0);
        chk("rst_ena", int'(dec_ena), 0);
        chk("rst_err", int'(err_count), 0);
        reset_n = 1'b1;
        enable = 1'b1;
        idle();
        chk("ena_on", int'(dec_ena), 1);
        word(8'hFC, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("k28_7_ignored", int'(sync_state), 0);
        good(8'hBC);
        chk("bc_data_ignored", int'(sync_state), 0);
        comma();
        chk("acq_state", int'(sync_state), 1);
        chk("acq_rdforce", int'(dec_rdforce), 0);
        comma();
        word(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("acq_kerr_state", int'(sync_state), 0);
        chk("acq_kerr_rdforce", int'(dec_rdforce), 1);
        chk("acq_kerr_err", int'(err_count), 0);
        comma();
        chk("c1_state", int'(sync_state), 1);
        comma();
        chk("c2_state", int'(sync_state), 1);
        comma();
        chk("c3_state", int'(sync_state), 2);
        chk("c3_link_up", int'(link_up), 1);
        good(8'h5A);
        chk("data_valid_5a", int'(data_valid), 1);
        chk("data_out_5a", int'(data_out), 8'h5A);
        word(8'h33, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rderr_dv", int'(data_valid), 0);
        chk("rderr_state", int'(sync_state), 3);
        chk("rderr_err", int'(err_count), 1);
        chk("rderr_hold_data", int'(data_out), 8'h5A);
        for (int i = 0; i < 3; i++) good(8'h10 + 8'(i));
        chk("rec_g3_state", int'(sync_state), 3);
        good(8'h20);
        chk("rec_g4_state", int'(sync_state), 2);
        good(8'h21);
        chk("rec_g5_state", int'(sync_state), 2);
        for (int i = 0; i < 3; i++) bad();
        chk("b3_state", int'(sync_state), 3);
        bad();
        chk("b4_state", int'(sync_state), 0);
        chk("b4_lol", int'(lol_count), 1);
        chk("b4_err", int'(err_count), 5);
        chk("b4_link_up", int'(link_up), 0);
        repeat (3) comma();
        bad();
        bad();
        chk("err7", int'(err_count), 7);
        word(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("clr_count_err", int'(err_count), 1);
        chk("clr_count_err_w2", int'(n_err_count), 1);
        chk("clr_count_lol", int'(lol_count), 0);
        bad();
        chk("loss2_state", int'(sync_state), 0);
        chk("loss2_lol", int'(lol_count), 1);
        repeat (3) comma();
        err_clr = 1'b1;
        idle();
        err_clr = 1'b0;
        chk("clr_only_err", int'(err_count), 0);
        repeat (3) bad();
        repeat (4) good(8'hA5);
        chk("retire_one_state", int'(sync_state), 3);
        bad();
        bad();
        chk("sat_w2", int'(n_err_count), 3);
        chk("sat_err16", int'(err_count), 5);
        chk("sat_lol", int'(lol_count), 1);
        chk("sat_state", int'(sync_state), 0);
        repeat (3) comma();
        chk("relock", int'(sync_state), 2);
        enable = 1'b0;
        good(8'h11);
        chk("dis_state", int'(sync_state), 0);
        chk("dis_dv", int'(data_valid), 0);
        chk("dis_lol", int'(lol_count), 1);
        chk("dis_ena", int'(dec_ena), 0);
        chk("dis_err", int'(err_count), 5);
        enable = 1'b1;
        repeat (3) comma();
        word(8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_dv", int'(data_valid), 1);
        reset_n = 1'b0;
        #1;
        chk("arst_state", int'(sync_state), 0);
        chk("arst_err", int'(err_count), 0);
        chk("arst_dv", int'(data_valid), 0);
        chk("arst_data", int'(data_out), 0);
        chk("arst_rdforce", int'(dec_rdforce), 1);
        idle();
        reset_n = 1'b1;
        repeat (3) idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
